// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_ctrl_if                                                     |
// | Producer-side bus of the 7-segment scan controller.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 8
);
    logic                  i_en;
    logic                  i_load;
    logic [4*DIGITS-1:0]   i_data;
    logic [DIGITS-1:0]     i_mask;
    logic [3:0]            o_num;
    logic [DIGITS-1:0]     o_an;
    logic                  o_frame_done;
    logic                  o_pending;

    modport master (
        output i_en, i_load, i_data, i_mask,
        input  o_num, o_an, o_frame_done, o_pending
    );

    modport slave (
        input  i_en, i_load, i_data, i_mask,
        output o_num, o_an, o_frame_done, o_pending
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_ctrl                                                        |
// | Tear-free time-multiplexed scanner for a common-anode 7-seg display. |
// | Optional leading-zero suppression: define SEG_SCAN_LZS_EN.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg_scan_ctrl #(
    parameter int DIGITS = 8,
    parameter int DIV    = 50000,
    parameter int GAP    = 2,
    parameter int CNT_W  = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    seg_scan_ctrl_if.slave bus
);

    localparam int               IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int               GAP_LAST_I = (GAP > 0) ? (GAP - 1) : 0;
    localparam logic [CNT_W-1:0] C_DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST = CNT_W'(GAP_LAST_I);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] C_AN_OFF  = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_wrap;
    logic                w_start;
    logic                w_apply;

    logic [4*DIGITS-1:0] r_sh_data;
    logic [DIGITS-1:0]   r_sh_mask;
    logic [4*DIGITS-1:0] r_act_data;
    logic [DIGITS-1:0]   r_act_mask;
    logic                r_pend;

    logic [3:0]          r_num;
    logic [DIGITS-1:0]   r_an;
    logic                r_frame_done;
    logic [3:0]          w_num_nxt;
    logic [DIGITS-1:0]   w_an_nxt;

    logic [3:0]          w_nib [DIGITS];
    logic [DIGITS-1:0]   w_blank;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_nib
            assign w_nib[k] = r_act_data[4*k +: 4];
        end
    endgenerate

`ifdef SEG_SCAN_LZS_EN
    // Digit k goes dark when it and every more-significant active nibble are zero.
    logic [DIGITS-1:0] w_lz;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_lzs
            if (k == 0) begin : g_d0
                assign w_lz[k] = 1'b0;
            end else begin : g_dk
                assign w_lz[k] = ~|r_act_data[4*DIGITS-1:4*k];
            end
        end
    endgenerate

    assign w_blank = r_act_mask | w_lz;
`else
    assign w_blank = r_act_mask;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_wrap      = 1'b0;
        w_start     = 1'b0;
        w_num_nxt   = r_num;
        w_an_nxt    = C_AN_OFF;

        case (r_state)
            ST_IDLE: begin
                w_num_nxt = 4'd0;
                if (bus.i_en) begin
                    w_state_nxt = ST_DRIVE;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_start     = 1'b1;
                end
            end
            ST_DRIVE: begin
                w_num_nxt = w_nib[r_idx];
                if (!w_blank[r_idx]) begin
                    w_an_nxt = ~(DIGITS'(1) << r_idx);
                end
                if (!bus.i_en) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_DIV_LAST) begin
                    w_cnt_nxt = '0;
                    if (GAP > 0) begin
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = ST_DRIVE;
                        w_wrap      = (r_idx == C_IDX_LAST);
                        w_idx_nxt   = w_wrap ? '0 : r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (!bus.i_en) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_GAP_LAST) begin
                    w_state_nxt = ST_DRIVE;
                    w_cnt_nxt   = '0;
                    w_wrap      = (r_idx == C_IDX_LAST);
                    w_idx_nxt   = w_wrap ? '0 : r_idx + IDX_W'(1);
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
                w_num_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Active registers only change when a fresh frame begins, so a frame never mixes old and new data.
    assign w_apply = w_start | w_wrap;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sh_data  <= '0;
            r_sh_mask  <= '0;
            r_act_data <= '0;
            r_act_mask <= '0;
            r_pend     <= 1'b0;
        end else if (bus.i_load) begin
            r_sh_data <= bus.i_data;
            r_sh_mask <= bus.i_mask;
            if (w_apply) begin
                r_act_data <= bus.i_data;
                r_act_mask <= bus.i_mask;
                r_pend     <= 1'b0;
            end else begin
                r_pend     <= 1'b1;
            end
        end else if (w_apply && r_pend) begin
            r_act_data <= r_sh_data;
            r_act_mask <= r_sh_mask;
            r_pend     <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_num        <= 4'd0;
            r_an         <= C_AN_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_num        <= w_num_nxt;
            r_an         <= w_an_nxt;
            r_frame_done <= w_wrap;
        end
    end

    assign bus.o_num        = r_num;
    assign bus.o_an         = r_an;
    assign bus.o_frame_done = r_frame_done;
    assign bus.o_pending    = r_pend;

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
- Shares one hex-to-segment decoder among all digits: presents one nibble per slot on o_num and enables that digit's anode.
- Sits between the data producer (CPU/MMIO or testbench) and the segment decoder.
- Tear-free: new data is applied only at frame boundaries.

Parameters:
- DIGITS, 8, number of digits scanned (1..16).
- DIV, 50000, clock cycles each digit is driven (>=1).
- GAP, 2, all-off dead cycles between digits, for anti-ghosting (0 = no gap state).
- CNT_W, 16, width of slot counter; must hold max(DIV,GAP)-1.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_en  input  1  scan enable; low = display dark.
- i_load  input  1  one-cycle strobe; capture i_data/i_mask into shadow registers.
- i_data  input  4*DIGITS  nibble k = digit k (bits 4k+3:4k); digit 0 is rightmost.
- i_mask  input  DIGITS  bit k = 1 blanks digit k.
- o_num  output  4  nibble for the segment decoder; registered.
- o_an  output  DIGITS  anode enables, active-low, at most one low; registered.
- o_frame_done  output  1  one-cycle pulse at end of each full scan.
- o_pending  output  1  shadow holds data not yet applied.

Behaviour:
- Reset (asynchronous): state IDLE, index 0, counter 0, shadow and active registers 0. Outputs: o_an all ones, o_num 0, o_frame_done 0, o_pending 0.
- Registers: shadow (data, mask) and active (data, mask). Only the active registers are displayed.
- States: IDLE, DRIVE, GAP.
- IDLE:
  - o_an all ones; o_num 0.
  - If i_en=1, go to DRIVE with index 0 and counter 0.
  - Any pending shadow is copied to active on the IDLE->DRIVE transition.
- DRIVE:
  - o_num = active nibble[index].
  - o_an bit[index] = 0 unless active mask[index]=1, in which case all ones.
  - Counter runs 0..DIV-1. When counter = DIV-1, go to GAP (or, if GAP=0, straight to the next slot); counter resets to 0.
- GAP:
  - o_an all ones; o_num holds its last value.
  - Counter runs 0..GAP-1, then index advances.
- Index advance and wrap:
  - Index increments by 1. At DIGITS-1 it wraps to 0.
  - On wrap: o_frame_done pulses on the same cycle the new DRIVE of digit 0 starts.
  - On wrap, if o_pending=1: copy shadow to active and clear o_pending in that same cycle.
- Latency: outputs are registered, one cycle after the state/index change.
  - i_en rising edge: first anode low 2 cycles later (IDLE->DRIVE, then output register).
- Load:
  - i_load=1 captures i_data/i_mask into shadow and sets o_pending.
  - Repeated loads before the frame boundary overwrite the shadow; the last one wins.
  - i_load on the same cycle as the wrap copy: the new i_data goes directly to both shadow and active; o_pending ends 0.
  - Load while IDLE: shadow captured; applied at the next IDLE->DRIVE transition.
- i_en deasserted mid-scan: next cycle state IDLE, index 0, counter 0, anodes off. No o_frame_done pulse. Shadow and active are retained.
- Reset mid-operation: immediate return to reset values, regardless of state.
- DIGITS=1: wrap occurs every slot; o_frame_done pulses once per DIV+GAP cycles.

Optional Feature:
- Macro: SEG_SCAN_LZS_EN (leading-zero suppression).
- Defined:
  - Digit k is additionally blanked when all active nibbles from k up to DIGITS-1 are 0 and k != 0.
  - Digit 0 is always shown.
  - Computed from the active registers only, so it changes at frame boundaries.
- Undefined: only i_mask controls blanking; zeros are displayed.

Test Plan (DIGITS=4, DIV=4, GAP=1 unless noted):
- Reset then i_en=1, load data 0x4321, mask 0 -> o_an sequence 1110(4 cycles), 1111(1), 1101(4), 1111(1), 1011, ..., 0111; o_num 1,2,3,4; o_frame_done pulses every 20 cycles.
- Load 0xABCD mid-frame while digit 1 is driven -> o_pending=1; digits 1-3 still show 2,3,4; at wrap o_num=D and o_pending=0.
- Mask 4'b0100 with data 0x4321 -> during slot 2 o_an=1111; o_num for the other slots is unchanged.
- i_en dropped during digit 2 -> next cycle IDLE, o_an=1111, no frame pulse; i_en re-raised -> scan restarts at digit 0.
- Assert i_rst asynchronously mid-DRIVE (not on a clock edge) -> o_an=1111, o_num=0, o_pending=0 immediately.
- With SEG_SCAN_LZS_EN, data 0x0050 -> digits 3 and 2 blanked; digits 1 and 0 show 5 and 0. With data 0x0000 -> only digit 0 lit, showing 0.
